// File: rtl/uart_byte_receiver.sv
`timescale 1ns/1ps
// 8N1 UART receiver: synchronizes rx_serial, deframes one LSB-first byte and
// holds it for the processor, flagging overrun and framing errors.
module uart_byte_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  input  logic       rx_trigger,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t             state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               line;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               cnt_run, data_tick, stop_ok, stop_bad;

  // Line synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
  end

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      rx_busy <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!line) state_next = ST_START;
      ST_START: if (cnt == CNT_HALF) state_next = line ? ST_IDLE : ST_DATA;
      ST_DATA:  if (data_tick && (bit_idx == 3'd7)) state_next = ST_STOP;
      ST_STOP:  if (cnt == CNT_LAST) state_next = line ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (line) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_run   = 1'b0;
    data_tick = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      ST_START: cnt_run = 1'b1;
      ST_DATA: begin
        cnt_run   = 1'b1;
        data_tick = (cnt == CNT_LAST);
      end
      ST_STOP: begin
        cnt_run  = 1'b1;
        stop_ok  = (cnt == CNT_LAST) && line;
        stop_bad = (cnt == CNT_LAST) && !line;
      end
      default: ;
    endcase
  end

  // Baud counter, shift register and processor-facing result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      rx_byte      <= 8'h00;
      rx_done      <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if ((state_next != state) || data_tick || !cnt_run) cnt <= '0;
      else                                                 cnt <= cnt + CNT_W'(1);

      if (state == ST_START) bit_idx <= 3'd0;
      else if (data_tick)    bit_idx <= bit_idx + 3'd1;

      if (data_tick) shift[bit_idx] <= line;

      // A fresh byte takes priority over an acknowledge in the same cycle
      if (stop_ok && (!rx_done || rx_trigger)) begin
        rx_byte <= shift;
        rx_done <= 1'b1;
      end else if (stop_ok) begin
        rx_overrun <= 1'b1;
      end else if (rx_trigger) begin
        rx_done      <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end

      if (stop_bad) rx_frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
`timescale 1ns/1ps
// Directed bench for uart_byte_receiver at 16 clocks per bit.
module tb_uart_byte_receiver;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic       rx_trigger;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;

  int n_cmp = 0;
  int n_err = 0;

  int         cyc, rise_at, rises, hi_run, hi_max;
  logic       prev_done, ovr_seen, busy_seen;
  logic [7:0] got_q[$];

  uart_byte_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial),
    .rx_trigger   (rx_trigger),
    .rx_byte      (rx_byte),
    .rx_done      (rx_done),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // One clock; observes outputs on the falling edge and records events
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rx_done && !prev_done) begin
      rises++;
      if (rise_at < 0) rise_at = cyc;
      got_q.push_back(rx_byte);
    end
    if (rx_done) hi_run++; else hi_run = 0;
    if (hi_run > hi_max) hi_max = hi_run;
    if (rx_overrun) ovr_seen = 1'b1;
    if (rx_busy) busy_seen = 1'b1;
    prev_done = rx_done;
  endtask

  task automatic hold(input logic v, input int n);
    rx_serial = v;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_bit, CPB);
  endtask

  task automatic clear_obs();
    cyc = 0; rise_at = -1; rises = 0; hi_run = 0; hi_max = 0;
    ovr_seen = 1'b0; busy_seen = 1'b0;
    got_q.delete();
    prev_done = rx_done;
  endtask

  task automatic ack();
    rx_trigger = 1'b1;
    step();
    rx_trigger = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_byte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", rx_done); end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    rst = 1'b0;
    clear_obs();
    hold(1'b1, 8);
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(8'hA5, 1'b1);
    n_cmp++; if (rise_at < 154 || rise_at > 156) begin n_err++; $display("FAIL single_latency: got %0d want 154..156", rise_at); end
    n_cmp++; if (rx_byte !== 8'hA5) begin n_err++; $display("FAIL single_byte: got %h want a5", rx_byte); end
    n_cmp++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", rx_done); end
    n_cmp++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin n_err++; $display("FAIL single_flags: got %b%b want 00", rx_overrun, rx_frame_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", rx_busy); end
    ack();
    n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL single_ack_done: got %b want 0", rx_done); end
    n_cmp++; if (rx_byte !== 8'hA5) begin n_err++; $display("FAIL single_ack_byte: got %h want a5", rx_byte); end
  endtask

  task automatic test_overrun();
    clear_obs();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 4);
    n_cmp++; if (rx_byte !== 8'h3C) begin n_err++; $display("FAIL overrun_byte: got %h want 3c", rx_byte); end
    n_cmp++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL overrun_done: got %b want 1", rx_done); end
    n_cmp++; if (rx_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag: got %b want 1", rx_overrun); end
    n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL overrun_rises: got %0d want 1", rises); end
    ack();
    n_cmp++; if ({rx_done, rx_overrun, rx_frame_err} !== 3'b000) begin n_err++; $display("FAIL overrun_ack: got %b%b%b want 000", rx_done, rx_overrun, rx_frame_err); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'h55, 1'b0);
    hold(1'b0, 40);
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", rx_frame_err); end
    n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL ferr_done: got %b want 0", rx_done); end
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_low_line: got %b want 1", rx_busy); end
    hold(1'b1, 6);
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_released: got %b want 0", rx_busy); end
    clear_obs();
    send_frame(8'h81, 1'b1);
    n_cmp++; if (rx_byte !== 8'h81) begin n_err++; $display("FAIL ferr_next_byte: got %h want 81", rx_byte); end
    n_cmp++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL ferr_next_done: got %b want 1", rx_done); end
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", rx_frame_err); end
    ack();
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_ack: got %b want 0", rx_frame_err); end
  endtask

  task automatic test_glitch();
    hold(1'b1, 4);
    clear_obs();
    hold(1'b0, 4);
    hold(1'b1, 20);
    n_cmp++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
    n_cmp++; if ({rx_done, rx_frame_err} !== 2'b00) begin n_err++; $display("FAIL glitch_flags: got %b%b want 00", rx_done, rx_frame_err); end
  endtask

  task automatic test_trigger_held();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h12;
    rx_trigger = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    hold(1'b1, 10);
    rx_trigger = 1'b0;
    n_cmp++; if (rises !== 3) begin n_err++; $display("FAIL held_pulses: got %0d want 3", rises); end
    n_cmp++; if (hi_max !== 1) begin n_err++; $display("FAIL held_pulse_width: got %0d want 1", hi_max); end
    n_cmp++; if (ovr_seen !== 1'b0) begin n_err++; $display("FAIL held_overrun: got %b want 0", ovr_seen); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] g;
      g = (got_q.size() > i) ? got_q[i] : 8'hxx;
      n_cmp++; if (g !== exp_b[i]) begin n_err++; $display("FAIL held_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
    n_cmp++; if (rx_byte !== 8'h12) begin n_err++; $display("FAIL held_byte_stable: got %h want 12", rx_byte); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    v = 8'h7E;
    clear_obs();
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(v[i], CPB);
    hold(v[4], CPB / 2);
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", rx_busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rx_byte !== 8'h00) begin n_err++; $display("FAIL mid_reset_byte: got %h want 00", rx_byte); end
    n_cmp++; if ({rx_done, rx_overrun, rx_frame_err, rx_busy} !== 4'b0000) begin n_err++; $display("FAIL mid_reset_flags: got %b%b%b%b want 0000", rx_done, rx_overrun, rx_frame_err, rx_busy); end
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 10);
    n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL mid_no_partial: got %b want 0", rx_done); end
    clear_obs();
    send_frame(8'h7E, 1'b1);
    n_cmp++; if (rx_byte !== 8'h7E) begin n_err++; $display("FAIL mid_next_byte: got %h want 7e", rx_byte); end
    n_cmp++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL mid_next_done: got %b want 1", rx_done); end
    n_cmp++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin n_err++; $display("FAIL mid_next_flags: got %b%b want 00", rx_overrun, rx_frame_err); end
  endtask

  initial begin
    rst = 1'b1;
    rx_serial = 1'b1;
    rx_trigger = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_trigger_held();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
